// File: rtl/gpio_apb_arb_if.sv
// Bundles the requester vld/ack bus and the APB master port of gpio_apb_arb.
// When GPIO_APB_ARB_LOCK_EN is defined, the bundle also carries the per-requester req_lock.
interface gpio_apb_arb_if #(
   parameter int NREQ = 2,
   parameter int IDW  = 2
);
   logic [NREQ-1:0]    req_vld;
   logic [NREQ-1:0]    req_write;
   logic [NREQ*5-1:0]  req_addr;
   logic [NREQ*32-1:0] req_wdata;
`ifdef GPIO_APB_ARB_LOCK_EN
   logic [NREQ-1:0]    req_lock;
`endif
   logic [NREQ-1:0]    req_ack;
   logic [31:0]        req_rdata;
   logic               arb_busy;
   logic [IDW-1:0]     arb_gnt_id;
   logic               psel;
   logic               penable;
   logic               pwrite;
   logic [4:0]         paddr;
   logic [31:0]        pwdata;
   logic [31:0]        prdata;

   // slave: the arbiter itself; master: requesters plus the gpio register block
   modport slave (
`ifdef GPIO_APB_ARB_LOCK_EN
      input  req_lock,
`endif
      input  req_vld, req_write, req_addr, req_wdata, prdata,
      output req_ack, req_rdata, arb_busy, arb_gnt_id,
      output psel, penable, pwrite, paddr, pwdata
   );

   modport master (
`ifdef GPIO_APB_ARB_LOCK_EN
      output req_lock,
`endif
      output req_vld, req_write, req_addr, req_wdata, prdata,
      input  req_ack, req_rdata, arb_busy, arb_gnt_id,
      input  psel, penable, pwrite, paddr, pwdata
   );
endinterface

// File: rtl/gpio_apb_arb.sv
// Round-robin arbiter running one APB setup+access transfer per grant into the gpio block.
// Define GPIO_APB_ARB_LOCK_EN to add req_lock: a bounded back-to-back re-grant of the same requester.
module gpio_apb_arb #(
   parameter int NREQ = 2,
   parameter int IDW  = 2
) (
   input  logic          pclk,
   input  logic          presetn,
   gpio_apb_arb_if.slave bus
);
   typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;

   localparam int LOCK_MAX = 4;

   state_t           state_reg, state_next;
   logic [IDW-1:0]   ptr_reg, ptr_next;
   logic [IDW-1:0]   gnt_reg, gnt_next;
   logic             psel_reg, psel_next;
   logic             penable_reg, penable_next;
   logic             pwrite_reg, pwrite_next;
   logic [4:0]       paddr_reg, paddr_next;
   logic [31:0]      pwdata_reg, pwdata_next;
   logic [31:0]      rdata_reg, rdata_next;
   logic [NREQ-1:0]  ack_reg, ack_next;
   logic             busy_reg, busy_next;
`ifdef GPIO_APB_ARB_LOCK_EN
   logic             lock_pend_reg, lock_pend_next;
   logic [2:0]       run_reg, run_next;
`endif

   logic [4:0]       addr_arr  [NREQ];
   logic [31:0]      wdata_arr [NREQ];
   logic [NREQ-1:0]  gnt_oh;
   logic [IDW-1:0]   rr_win;
   logic             rr_found;
   logic [IDW-1:0]   win;
   logic             adv;

   generate
      for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
         assign addr_arr[gi]  = bus.req_addr[5*gi +: 5];
         assign wdata_arr[gi] = bus.req_wdata[32*gi +: 32];
      end
   endgenerate

   assign gnt_oh = {{(NREQ-1){1'b0}}, 1'b1} << gnt_reg;

   // First valid requester at or after the pointer, wrapping at NREQ (not at 2**IDW).
   always_comb begin
      rr_found = 1'b0;
      rr_win   = '0;
      for (int k = 0; k < NREQ; k++) begin
         if (!rr_found && bus.req_vld[(int'(ptr_reg) + k) % NREQ]) begin
            rr_found = 1'b1;
            rr_win   = IDW'((int'(ptr_reg) + k) % NREQ);
         end
      end
   end

   always_comb begin
      state_next   = state_reg;
      ptr_next     = ptr_reg;
      gnt_next     = gnt_reg;
      psel_next    = psel_reg;
      penable_next = penable_reg;
      pwrite_next  = pwrite_reg;
      paddr_next   = paddr_reg;
      pwdata_next  = pwdata_reg;
      rdata_next   = rdata_reg;
      ack_next     = '0;
      win          = rr_win;
      adv          = 1'b1;
`ifdef GPIO_APB_ARB_LOCK_EN
      lock_pend_next = lock_pend_reg;
      run_next       = run_reg;
`endif
      case (state_reg)
         IDLE: begin
`ifdef GPIO_APB_ARB_LOCK_EN
            lock_pend_next = 1'b0;
`endif
            if (|bus.req_vld) begin
`ifdef GPIO_APB_ARB_LOCK_EN
               run_next = 3'd1;
               // A locked re-grant leaves the pointer where the last normal grant put it.
               if (lock_pend_reg && |(bus.req_vld & gnt_oh)) begin
                  win      = gnt_reg;
                  adv      = 1'b0;
                  run_next = run_reg + 3'd1;
               end
`endif
               gnt_next = win;
               if (adv) begin
                  ptr_next = (int'(win) == NREQ - 1) ? '0 : win + 1'b1;
               end
               for (int k = 0; k < NREQ; k++) begin
                  if (int'(win) == k) begin
                     pwrite_next = bus.req_write[k];
                     paddr_next  = addr_arr[k];
                     pwdata_next = wdata_arr[k];
                  end
               end
               psel_next  = 1'b1;
               state_next = SETUP;
            end
         end
         SETUP: begin
            penable_next = 1'b1;
            state_next   = ACCESS;
         end
         ACCESS: begin
            psel_next    = 1'b0;
            penable_next = 1'b0;
            ack_next     = gnt_oh;
            rdata_next   = pwrite_reg ? 32'h0 : bus.prdata;
            state_next   = DONE;
         end
         DONE: begin
            state_next = IDLE;
`ifdef GPIO_APB_ARB_LOCK_EN
            lock_pend_next = |(bus.req_lock & gnt_oh) && (run_reg < 3'(LOCK_MAX));
`endif
         end
         default: state_next = IDLE;
      endcase
   end

   assign busy_next = (state_next != IDLE);

   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) begin
         state_reg   <= IDLE;
         ptr_reg     <= '0;
         gnt_reg     <= '0;
         psel_reg    <= 1'b0;
         penable_reg <= 1'b0;
         pwrite_reg  <= 1'b0;
         paddr_reg   <= '0;
         pwdata_reg  <= '0;
         rdata_reg   <= '0;
         ack_reg     <= '0;
         busy_reg    <= 1'b0;
`ifdef GPIO_APB_ARB_LOCK_EN
         lock_pend_reg <= 1'b0;
         run_reg       <= '0;
`endif
      end else begin
         state_reg   <= state_next;
         ptr_reg     <= ptr_next;
         gnt_reg     <= gnt_next;
         psel_reg    <= psel_next;
         penable_reg <= penable_next;
         pwrite_reg  <= pwrite_next;
         paddr_reg   <= paddr_next;
         pwdata_reg  <= pwdata_next;
         rdata_reg   <= rdata_next;
         ack_reg     <= ack_next;
         busy_reg    <= busy_next;
`ifdef GPIO_APB_ARB_LOCK_EN
         lock_pend_reg <= lock_pend_next;
         run_reg       <= run_next;
`endif
      end
   end

   assign bus.psel       = psel_reg;
   assign bus.penable    = penable_reg;
   assign bus.pwrite     = pwrite_reg;
   assign bus.paddr      = paddr_reg;
   assign bus.pwdata     = pwdata_reg;
   assign bus.req_ack    = ack_reg;
   assign bus.req_rdata  = rdata_reg;
   assign bus.arb_busy   = busy_reg;
   assign bus.arb_gnt_id = gnt_reg;
endmodule

// File: tb/tb_gpio_apb_arb.sv
// Bench for gpio_apb_arb: queue-driven requesters, a transfer-level model checked every cycle,
// and literal checks of latency, grant order, mid-transfer reset and (with GPIO_APB_ARB_LOCK_EN) lock.
module tb_gpio_apb_arb;
   localparam int NREQ = 2;
   localparam int IDW  = 2;

   typedef struct {
      logic        write;
      logic [4:0]  addr;
      logic [31:0] wdata;
      logic        lock;
      logic        drop;
   } cmd_t;

   logic pclk = 1'b0;
   logic presetn = 1'b0;
   int   cyc = 0;
   int   n_vec = 0;
   int   n_err = 0;

   cmd_t rq [NREQ][$];

   int          psel_cyc[$];
   int          pen_cyc[$];
   logic [31:0] pen_wdata[$];
   int          busy_fall[$];
   int          ack_id[$];
   int          ack_cyc[$];
   logic [31:0] ack_rdata[$];

   // transfer-level model state
   bit          m_active;
   int          m_gcyc;
   int          m_id;
   int          m_ptr;
   logic        m_write;
   logic [4:0]  m_addr;
   logic [31:0] m_wdata;
   logic [31:0] m_rdata;
`ifdef GPIO_APB_ARB_LOCK_EN
   bit          m_lock_offer;
   int          m_run;
`endif

   always #5 pclk = ~pclk;
   always @(posedge pclk) cyc <= cyc + 1;

   gpio_apb_arb_if #(.NREQ(NREQ), .IDW(IDW)) bus ();

   gpio_apb_arb #(.NREQ(NREQ), .IDW(IDW)) dut (
      .pclk    (pclk),
      .presetn (presetn),
      .bus     (bus)
   );

   function automatic logic [31:0] prdata_of(input logic [4:0] a);
      return (a == 5'h14) ? 32'h0000_003C : {8'hD0, 3'b000, a, 16'h1234};
   endfunction

   assign bus.prdata = prdata_of(bus.paddr);

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
      end
   endtask

   task automatic push(input int r, input logic w, input logic [4:0] a, input logic [31:0] d,
                       input logic lk, input logic dr);
      cmd_t c;
      c.write = w; c.addr = a; c.wdata = d; c.lock = lk; c.drop = dr;
      rq[r].push_back(c);
   endtask

   task automatic wait_idle(input string name, input int budget);
      int n;
      n = 0;
      do begin
         @(negedge pclk); #1;
         n++;
      end while ((rq[0].size() != 0 || rq[1].size() != 0 || m_active) && n < budget);
      if (n >= budget) begin
         n_vec++;
         n_err++;
         $display("FAIL %s timeout: got busy after %0d cycles, required idle", name, n);
      end
   endtask

   // Requesters: hold vld/payload until ack, pop on the edge that samples ack.
   initial begin : driver
      logic [NREQ-1:0] ack_s;
      logic            setup_s;
      logic [IDW-1:0]  gnt_s;
      bit              dropped [NREQ];
      bus.req_vld   = '0;
      bus.req_write = '0;
      bus.req_addr  = '0;
      bus.req_wdata = '0;
`ifdef GPIO_APB_ARB_LOCK_EN
      bus.req_lock  = '0;
`endif
      for (int i = 0; i < NREQ; i++) dropped[i] = 1'b0;
      forever begin
         @(negedge pclk);
         ack_s   = bus.req_ack;
         setup_s = bus.psel & ~bus.penable;
         gnt_s   = bus.arb_gnt_id;
         @(posedge pclk); #1;
         for (int i = 0; i < NREQ; i++) begin
            if (ack_s[i] && rq[i].size() != 0) begin
               void'(rq[i].pop_front());
               dropped[i] = 1'b0;
            end else if (setup_s && int'(gnt_s) == i && rq[i].size() != 0 && rq[i][0].drop) begin
               dropped[i] = 1'b1;
            end
            if (rq[i].size() != 0 && !dropped[i]) begin
               bus.req_vld[i]            = 1'b1;
               bus.req_write[i]          = rq[i][0].write;
               bus.req_addr[5*i +: 5]    = rq[i][0].addr;
               bus.req_wdata[32*i +: 32] = rq[i][0].wdata;
`ifdef GPIO_APB_ARB_LOCK_EN
               bus.req_lock[i]           = rq[i][0].lock;
`endif
            end else begin
               bus.req_vld[i] = 1'b0;
`ifdef GPIO_APB_ARB_LOCK_EN
               bus.req_lock[i] = 1'b0;
`endif
               if (dropped[i]) begin
                  bus.req_addr[5*i +: 5]    = ~rq[i][0].addr;
                  bus.req_wdata[32*i +: 32] = ~rq[i][0].wdata;
               end
            end
         end
      end
   end

   // Every cycle: compare DUT outputs to the model, log events, then advance the model.
   initial begin : compare
      int   age;
      int   w;
      logic prev_psel, prev_pen, prev_busy;
      prev_psel = 1'b0; prev_pen = 1'b0; prev_busy = 1'b0;
      forever begin
         @(negedge pclk);
         if (!presetn) begin
            chk("rst_psel", bus.psel, 32'h0);
            chk("rst_penable", bus.penable, 32'h0);
            chk("rst_ack", bus.req_ack, 32'h0);
            chk("rst_busy", bus.arb_busy, 32'h0);
            chk("rst_gnt_id", bus.arb_gnt_id, 32'h0);
            chk("rst_paddr", bus.paddr, 32'h0);
            chk("rst_rdata", bus.req_rdata, 32'h0);
            m_active = 1'b0; m_gcyc = 0; m_id = 0; m_ptr = 0;
            m_write = 1'b0; m_addr = '0; m_wdata = '0; m_rdata = '0;
`ifdef GPIO_APB_ARB_LOCK_EN
            m_lock_offer = 1'b0; m_run = 0;
`endif
            prev_psel = 1'b0; prev_pen = 1'b0; prev_busy = 1'b0;
         end else begin
            age = cyc - m_gcyc;
            if (m_active && age == 3) m_rdata = m_write ? 32'h0 : prdata_of(m_addr);
            chk("psel", bus.psel, 32'(m_active && (age == 1 || age == 2)));
            chk("penable", bus.penable, 32'(m_active && age == 2));
            chk("req_ack", bus.req_ack, (m_active && age == 3) ? (32'h1 << m_id) : 32'h0);
            chk("arb_busy", bus.arb_busy, 32'(m_active));
            chk("arb_gnt_id", bus.arb_gnt_id, m_id);
            chk("paddr", bus.paddr, m_addr);
            chk("pwrite", bus.pwrite, m_write);
            chk("pwdata", bus.pwdata, m_wdata);
            chk("req_rdata", bus.req_rdata, m_rdata);

            if (bus.psel && !prev_psel) psel_cyc.push_back(cyc);
            if (bus.penable && !prev_pen) begin
               pen_cyc.push_back(cyc);
               pen_wdata.push_back(bus.pwdata);
            end
            if (!bus.arb_busy && prev_busy) busy_fall.push_back(cyc);
            for (int k = 0; k < NREQ; k++) begin
               if (bus.req_ack[k]) begin
                  ack_id.push_back(k);
                  ack_cyc.push_back(cyc);
                  ack_rdata.push_back(bus.req_rdata);
               end
            end
            prev_psel = bus.psel; prev_pen = bus.penable; prev_busy = bus.arb_busy;

            if (m_active && age == 3) begin
               m_active = 1'b0;
`ifdef GPIO_APB_ARB_LOCK_EN
               m_lock_offer = bus.req_lock[m_id] && (m_run < 4);
`endif
            end else if (!m_active) begin
               w = -1;
               if (bus.req_vld != '0) begin
`ifdef GPIO_APB_ARB_LOCK_EN
                  if (m_lock_offer && bus.req_vld[m_id]) begin
                     w = m_id;
                     m_run++;
                  end
`endif
                  if (w < 0) begin
                     for (int k = 0; k < NREQ; k++)
                        if (w < 0 && bus.req_vld[(m_ptr + k) % NREQ]) w = (m_ptr + k) % NREQ;
                     m_ptr = (w + 1) % NREQ;
`ifdef GPIO_APB_ARB_LOCK_EN
                     m_run = 1;
`endif
                  end
                  m_id     = w;
                  m_write  = bus.req_write[w];
                  m_addr   = bus.req_addr[5*w +: 5];
                  m_wdata  = bus.req_wdata[32*w +: 32];
                  m_active = 1'b1;
                  m_gcyc   = cyc;
               end
`ifdef GPIO_APB_ARB_LOCK_EN
               m_lock_offer = 1'b0;
`endif
            end
         end
      end
   end

   initial begin : main
      int c0;
      int base;
      int n;
      int exp4 [4];
      int exp6 [5];
      exp4 = '{0, 1, 0, 1};
`ifdef GPIO_APB_ARB_LOCK_EN
      exp6 = '{0, 0, 0, 0, 1};
`else
      exp6 = '{0, 1, 0, 0, 0};
`endif
      presetn = 1'b0;
      repeat (3) @(negedge pclk);
      @(posedge pclk); #3 presetn = 1'b1;

      // idle with nothing requested
      repeat (6) @(negedge pclk);
      #2;
      chk("t1_idle_busy", bus.arb_busy, 32'h0);
      chk("t1_idle_psel", bus.psel, 32'h0);
      chk("t1_no_ack", ack_id.size(), 32'h0);

      // req0 write 5'h01 <- A5: psel at +1, penable at +2, ack at +3, idle at +4
      @(negedge pclk); #2;
      c0 = cyc + 1;
      base = ack_id.size();
      push(0, 1'b1, 5'h01, 32'h0000_00A5, 1'b0, 1'b0);
      wait_idle("t2", 40);
      chk("t2_psel_cycle", psel_cyc[psel_cyc.size()-1], c0 + 1);
      chk("t2_penable_cycle", pen_cyc[pen_cyc.size()-1], c0 + 2);
      chk("t2_pwdata", pen_wdata[pen_wdata.size()-1], 32'h0000_00A5);
      chk("t2_ack_cycle", ack_cyc[ack_cyc.size()-1], c0 + 3);
      chk("t2_ack_id", ack_id[ack_id.size()-1], 0);
      chk("t2_busy_low_cycle", busy_fall[busy_fall.size()-1], c0 + 4);
      chk("t2_ack_count", ack_id.size() - base, 1);

      // req1 read 5'h14, slave returns 3C
      @(negedge pclk); #2;
      base = ack_id.size();
      push(1, 1'b0, 5'h14, 32'h0, 1'b0, 1'b0);
      wait_idle("t3", 40);
      chk("t3_ack_id", ack_id[ack_id.size()-1], 1);
      chk("t3_rdata", ack_rdata[ack_rdata.size()-1], 32'h0000_003C);
      chk("t3_ack_count", ack_id.size() - base, 1);

      // both requesters held valid for four transfers
      @(negedge pclk); #2;
      base = ack_id.size();
      push(0, 1'b1, 5'h02, 32'h1111_0002, 1'b0, 1'b0);
      push(0, 1'b1, 5'h03, 32'h1111_0003, 1'b0, 1'b0);
      push(1, 1'b0, 5'h04, 32'h0, 1'b0, 1'b0);
      push(1, 1'b0, 5'h05, 32'h0, 1'b0, 1'b0);
      wait_idle("t4", 80);
      chk("t4_ack_count", ack_id.size() - base, 4);
      for (int j = 0; j < 4; j++) chk("t4_grant_order", ack_id[base + j], exp4[j]);

      // reset during ACCESS: in-flight read dropped, then re-served after release
      @(negedge pclk); #2;
      base = ack_id.size();
      push(0, 1'b0, 5'h03, 32'h0, 1'b0, 1'b0);
      n = 0;
      do begin
         @(negedge pclk); #2;
         n++;
      end while (!bus.penable && n < 20);
      chk("t5_reached_access", bus.penable, 32'h1);
      presetn = 1'b0;
      #1;
      chk("t5_async_psel", bus.psel, 32'h0);
      chk("t5_async_penable", bus.penable, 32'h0);
      chk("t5_async_ack", bus.req_ack, 32'h0);
      chk("t5_async_busy", bus.arb_busy, 32'h0);
      repeat (2) @(negedge pclk);
      @(posedge pclk); #3 presetn = 1'b1;
      wait_idle("t5", 40);
      chk("t5_ack_count", ack_id.size() - base, 1);
      chk("t5_ack_id", ack_id[ack_id.size()-1], 0);
      chk("t5_rdata", ack_rdata[ack_rdata.size()-1], 32'hD003_1234);

      // req1 drops vld and scrambles payload after grant; latched write still completes
      @(negedge pclk); #2;
      base = ack_id.size();
      push(1, 1'b1, 5'h06, 32'hDEAD_BEEF, 1'b0, 1'b1);
      wait_idle("t7", 40);
      chk("t7_ack_count", ack_id.size() - base, 1);
      chk("t7_ack_id", ack_id[ack_id.size()-1], 1);
      chk("t7_pwdata_latched", pen_wdata[pen_wdata.size()-1], 32'hDEAD_BEEF);
      chk("t7_rdata_write", ack_rdata[ack_rdata.size()-1], 32'h0);

      // req0 locked with vld held, req1 pending
      @(negedge pclk); #2;
      base = ack_id.size();
      for (int j = 0; j < 5; j++) push(0, 1'b1, 5'(8 + j), 32'(32'h100 + j), 1'b1, 1'b0);
      push(1, 1'b0, 5'h09, 32'h0, 1'b0, 1'b0);
      wait_idle("t6", 200);
      chk("t6_ack_count", ack_id.size() - base, 6);
      for (int j = 0; j < 5; j++) chk("t6_grant_order", ack_id[base + j], exp6[j]);

      repeat (3) @(negedge pclk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: got no completion, required finish before time limit");
      $fatal(1, "watchdog expired");
   end
endmodule
